alu_issue_sched: RTL and testbench

Issue and writeback scheduler placed between the decode stage and the integer execution datapath (single-cycle shift/logic/add path, multi-cycle multiplier, variable-latency divider). It accepts one operation per cycle from decode over a valid/ready handshake and steers it to the correct unit. It allows at most one outstanding long (mul/div) operation and blocks write-after-write hazards against it. It merges all completions onto a single register-file write port, using a one-entry hold buffer to resolve collisions.

---
 rtl/alu_issue_sched.sv | 160 ++++++++++++++++
 tb/tb_alu_issue_sched.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_sched.sv
// Issue/writeback scheduler: steers decode ops to fast/mul/div units and merges completions onto one write port.
// Optional perf counters are enabled by defining ALU_SCHED_PERF_EN.
module alu_issue_sched #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            issue_vld,
    output logic            issue_rdy,
    input  logic [1:0]      issue_cls,
    input  logic [4:0]      issue_dst,
    output logic            fast_req,
    output logic            mul_req,
    output logic            div_req,
    input  logic            fast_vld,
    input  logic [XLEN-1:0] fast_res,
    input  logic            mul_done,
    input  logic            div_done,
    input  logic [XLEN-1:0] mul_res,
    input  logic [XLEN-1:0] div_res,
    output logic            wb_vld,
    output logic [4:0]      wb_addr,
    output logic [XLEN-1:0] wb_data,
    output logic            busy_vld,
    output logic [4:0]      busy_dst
`ifdef ALU_SCHED_PERF_EN
    ,
    output logic [31:0]     perf_stall_cnt,
    output logic [31:0]     perf_coll_cnt
`endif
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MUL_BUSY = 2'd1,
        DIV_BUSY = 2'd2
    } state_t;

    state_t            state_reg;
    logic [4:0]        busy_dst_reg;
    logic [4:0]        fast_dst_reg;
    logic              hold_vld_reg;
    logic [4:0]        hold_addr_reg;
    logic [XLEN-1:0]   hold_data_reg;

    logic              accept;
    logic              long_done;
    logic [XLEN-1:0]   long_res;
    logic              hold_capture;

    assign busy_vld = (state_reg != IDLE);
    assign busy_dst = busy_dst_reg;

    // Fast ops only stall on a WAW hazard against the outstanding long op; x0 never conflicts.
    always_comb begin
        issue_rdy = 1'b0;
        if (rst_n && !hold_vld_reg) begin
            case (issue_cls)
                2'b00:   issue_rdy = !(busy_vld && (issue_dst == busy_dst_reg) && (issue_dst != 5'd0));
                2'b01,
                2'b10:   issue_rdy = (state_reg == IDLE);
                default: issue_rdy = 1'b0;
            endcase
        end
    end

    assign accept   = issue_vld && issue_rdy;
    assign fast_req = accept && (issue_cls == 2'b00);
    assign mul_req  = accept && (issue_cls == 2'b01);
    assign div_req  = accept && (issue_cls == 2'b10);

    // Done pulses are only honoured from the unit that actually owns the outstanding op.
    always_comb begin
        long_done = 1'b0;
        long_res  = '0;
        if (state_reg == MUL_BUSY && mul_done) begin
            long_done = 1'b1;
            long_res  = mul_res;
        end else if (state_reg == DIV_BUSY && div_done) begin
            long_done = 1'b1;
            long_res  = div_res;
        end
    end

    assign hold_capture = rst_n && long_done && fast_vld;

    always_comb begin
        wb_vld  = 1'b0;
        wb_addr = 5'd0;
        wb_data = '0;
        if (rst_n) begin
            if (long_done) begin
                wb_vld  = 1'b1;
                wb_addr = busy_dst_reg;
                wb_data = long_res;
            end else if (fast_vld) begin
                wb_vld  = 1'b1;
                wb_addr = fast_dst_reg;
                wb_data = fast_res;
            end else if (hold_vld_reg) begin
                wb_vld  = 1'b1;
                wb_addr = hold_addr_reg;
                wb_data = hold_data_reg;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            busy_dst_reg  <= 5'd0;
            fast_dst_reg  <= 5'd0;
            hold_vld_reg  <= 1'b0;
            hold_addr_reg <= 5'd0;
            hold_data_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (mul_req) begin
                        state_reg    <= MUL_BUSY;
                        busy_dst_reg <= issue_dst;
                    end else if (div_req) begin
                        state_reg    <= DIV_BUSY;
                        busy_dst_reg <= issue_dst;
                    end
                end
                MUL_BUSY: if (mul_done) state_reg <= IDLE;
                DIV_BUSY: if (div_done) state_reg <= IDLE;
                default:  state_reg <= IDLE;
            endcase

            if (fast_req)
                fast_dst_reg <= issue_dst;

            // Capture uses the current fast_dst before a same-cycle fast issue overwrites it.
            if (hold_capture) begin
                hold_vld_reg  <= 1'b1;
                hold_addr_reg <= fast_dst_reg;
                hold_data_reg <= fast_res;
            end else if (hold_vld_reg && !long_done && !fast_vld) begin
                hold_vld_reg  <= 1'b0;
            end
        end
    end

`ifdef ALU_SCHED_PERF_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_stall_cnt <= 32'd0;
            perf_coll_cnt  <= 32'd0;
        end else begin
            if (issue_vld && !issue_rdy)
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
            if (hold_capture)
                perf_coll_cnt  <= perf_coll_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_alu_issue_sched.sv
// Directed bench for alu_issue_sched; the bench models the fast unit (1-cycle) and drives long-unit done pulses by hand.
module tb_alu_issue_sched;

    localparam int XLEN = 64;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            issue_vld;
    logic            issue_rdy;
    logic [1:0]      issue_cls;
    logic [4:0]      issue_dst;
    logic            fast_req, mul_req, div_req;
    logic            fast_vld;
    logic [XLEN-1:0] fast_res;
    logic            mul_done, div_done;
    logic [XLEN-1:0] mul_res, div_res;
    logic            wb_vld;
    logic [4:0]      wb_addr;
    logic [XLEN-1:0] wb_data;
    logic            busy_vld;
    logic [4:0]      busy_dst;
    logic [XLEN-1:0] fast_in;
`ifdef ALU_SCHED_PERF_EN
    logic [31:0]     perf_stall_cnt, perf_coll_cnt;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_issue_sched #(.XLEN(XLEN)) dut (
        .clk(clk), .rst_n(rst_n),
        .issue_vld(issue_vld), .issue_rdy(issue_rdy), .issue_cls(issue_cls), .issue_dst(issue_dst),
        .fast_req(fast_req), .mul_req(mul_req), .div_req(div_req),
        .fast_vld(fast_vld), .fast_res(fast_res),
        .mul_done(mul_done), .div_done(div_done), .mul_res(mul_res), .div_res(div_res),
        .wb_vld(wb_vld), .wb_addr(wb_addr), .wb_data(wb_data),
        .busy_vld(busy_vld), .busy_dst(busy_dst)
`ifdef ALU_SCHED_PERF_EN
        , .perf_stall_cnt(perf_stall_cnt), .perf_coll_cnt(perf_coll_cnt)
`endif
    );

    // Fast unit model: result one cycle after the request, data supplied alongside the issue.
    always @(posedge clk) begin
        fast_vld <= rst_n && fast_req;
        fast_res <= fast_in;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic vld, input logic [1:0] cls, input logic [4:0] dst, input logic [XLEN-1:0] data);
        issue_vld = vld;
        issue_cls = cls;
        issue_dst = dst;
        fast_in   = data;
        #1;
    endtask

    task automatic chk(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
        $display("check %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic chk_wb(input string tag, input logic [4:0] addr, input logic [XLEN-1:0] data);
        chk({tag, "_vld"}, XLEN'(wb_vld), 1);
        chk({tag, "_addr"}, XLEN'(wb_addr), XLEN'(addr));
        chk({tag, "_data"}, wb_data, data);
    endtask

    initial begin
        rst_n = 1'b0; issue_vld = 1'b0; issue_cls = 2'b00; issue_dst = 5'd0; fast_in = '0;
        mul_done = 1'b0; div_done = 1'b0; mul_res = '0; div_res = '0;
        fast_vld = 1'b0; fast_res = '0;

        // Reset: issue_rdy must stay low even with a valid fast op presented
        tick(); tick();
        issue(1'b1, 2'b00, 5'd3, 64'h1);
        chk("rst_rdy", XLEN'(issue_rdy), 0);
        chk("rst_fast_req", XLEN'(fast_req), 0);
        chk("rst_wb_vld", XLEN'(wb_vld), 0);
        chk("rst_busy_vld", XLEN'(busy_vld), 0);
        chk("rst_busy_dst", XLEN'(busy_dst), 0);
        tick();
        rst_n = 1'b1;
        issue(1'b0, 2'b00, 5'd0, 64'h0);

        // Back-to-back fast ops
        issue(1'b1, 2'b00, 5'd1, 64'h11);
        chk("ff_rdy0", XLEN'(issue_rdy), 1);
        chk("ff_req0", XLEN'(fast_req), 1);
        chk("ff_wb0", XLEN'(wb_vld), 0);
        tick();
        issue(1'b1, 2'b00, 5'd2, 64'h22);
        chk("ff_rdy1", XLEN'(issue_rdy), 1);
        chk_wb("ff_wb1", 5'd1, 64'h11);
        tick();
        issue(1'b1, 2'b00, 5'd3, 64'h33);
        chk("ff_rdy2", XLEN'(issue_rdy), 1);
        chk_wb("ff_wb2", 5'd2, 64'h22);
        tick();
        issue(1'b0, 2'b00, 5'd0, 64'h0);
        chk_wb("ff_wb3", 5'd3, 64'h33);
        tick();
        chk("ff_wb4", XLEN'(wb_vld), 0);

        // Mul dst 5 then a second mul blocked until done
        issue(1'b1, 2'b01, 5'd5, 64'h0);
        chk("mul_rdy0", XLEN'(issue_rdy), 1);
        chk("mul_req0", XLEN'(mul_req), 1);
        tick();
        issue(1'b1, 2'b01, 5'd6, 64'h0);
        chk("mul_rdy1", XLEN'(issue_rdy), 0);
        chk("mul_req1", XLEN'(mul_req), 0);
        chk("mul_busy1", XLEN'(busy_vld), 1);
        chk("mul_bdst1", XLEN'(busy_dst), 5);
        tick();
        chk("mul_rdy2", XLEN'(issue_rdy), 0);
        tick();
        chk("mul_rdy3", XLEN'(issue_rdy), 0);
        tick();
        mul_done = 1'b1; mul_res = 64'h55;
        #1;
        chk("mul_rdy4", XLEN'(issue_rdy), 0);
        chk("mul_bdst4", XLEN'(busy_dst), 5);
        chk_wb("mul_wb4", 5'd5, 64'h55);
        tick();
        mul_done = 1'b0;
        #1;
        chk("mul_rdy5", XLEN'(issue_rdy), 1);
        chk("mul_req5", XLEN'(mul_req), 1);
        chk("mul_busy5", XLEN'(busy_vld), 0);
        tick();
        issue(1'b0, 2'b00, 5'd0, 64'h0);
        chk("mul_bdst6", XLEN'(busy_dst), 6);
        mul_done = 1'b1; mul_res = 64'h66;
        #1;
        chk_wb("mul_wb6", 5'd6, 64'h66);
        tick();
        mul_done = 1'b0;
        #1;
        chk("mul_busy7", XLEN'(busy_vld), 0);

        // Div dst 7: WAW stall for fast dst 7, fast dst 0 passes
        issue(1'b1, 2'b10, 5'd7, 64'h0);
        chk("div_req", XLEN'(div_req), 1);
        tick();
        issue(1'b1, 2'b00, 5'd7, 64'h77);
        chk("waw_rdy0", XLEN'(issue_rdy), 0);
        tick();
        issue(1'b1, 2'b00, 5'd0, 64'h0F);
        chk("x0_rdy", XLEN'(issue_rdy), 1);
        chk("x0_req", XLEN'(fast_req), 1);
        tick();
        issue(1'b1, 2'b00, 5'd7, 64'h77);
        chk("waw_rdy1", XLEN'(issue_rdy), 0);
        chk_wb("x0_wb", 5'd0, 64'h0F);
        tick();
        div_done = 1'b1; div_res = 64'h70;
        #1;
        chk("waw_rdy2", XLEN'(issue_rdy), 0);
        chk_wb("div_wb", 5'd7, 64'h70);
        tick();
        div_done = 1'b0;
        #1;
        chk("waw_rdy3", XLEN'(issue_rdy), 1);
        chk("waw_req3", XLEN'(fast_req), 1);
        tick();
        issue(1'b0, 2'b00, 5'd0, 64'h0);
        chk_wb("waw_wb", 5'd7, 64'h77);
        tick();

        // Collision: div dst 9 done together with fast dst 4
        issue(1'b1, 2'b10, 5'd9, 64'h0);
        tick();
        issue(1'b1, 2'b00, 5'd4, 64'hAA);
        chk("col_rdy", XLEN'(issue_rdy), 1);
        tick();
        issue(1'b0, 2'b00, 5'd0, 64'h0);
        div_done = 1'b1; div_res = 64'h99;
        #1;
        chk_wb("col_wb0", 5'd9, 64'h99);
        tick();
        div_done = 1'b0;
        issue(1'b1, 2'b00, 5'd1, 64'h0);
        chk("col_rdy1", XLEN'(issue_rdy), 0);
        chk_wb("col_wb1", 5'd4, 64'hAA);
        tick();
        issue(1'b0, 2'b00, 5'd0, 64'h0);
        chk("col_wb2", XLEN'(wb_vld), 0);
        chk("col_rdy2", XLEN'(issue_rdy), 1);

        // Collision with a trailing fast op issued in the collision cycle
        issue(1'b1, 2'b01, 5'd10, 64'h0);
        tick();
        issue(1'b1, 2'b00, 5'd11, 64'hB1);
        tick();
        mul_done = 1'b1; mul_res = 64'hA0;
        issue(1'b1, 2'b00, 5'd12, 64'hC2);
        chk("tr_req", XLEN'(fast_req), 1);
        chk_wb("tr_wb0", 5'd10, 64'hA0);
        tick();
        mul_done = 1'b0;
        issue(1'b0, 2'b00, 5'd0, 64'h0);
        chk("tr_rdy1", XLEN'(issue_rdy), 0);
        chk_wb("tr_wb1", 5'd12, 64'hC2);
        tick();
        chk_wb("tr_wb2", 5'd11, 64'hB1);
        tick();
        chk("tr_wb3", XLEN'(wb_vld), 0);

        // Reset mid-div, done suppressed
        issue(1'b1, 2'b10, 5'd13, 64'h0);
        tick();
        issue(1'b0, 2'b00, 5'd0, 64'h0);
        tick();
        rst_n = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        issue(1'b1, 2'b10, 5'd14, 64'h0);
        chk("rr_busy", XLEN'(busy_vld), 0);
        chk("rr_wb", XLEN'(wb_vld), 0);
        chk("rr_rdy", XLEN'(issue_rdy), 1);
        chk("rr_req", XLEN'(div_req), 1);
`ifdef ALU_SCHED_PERF_EN
        chk("rr_stall_cnt", XLEN'(perf_stall_cnt), 0);
        chk("rr_coll_cnt", XLEN'(perf_coll_cnt), 0);
`endif
        tick();
        issue(1'b0, 2'b00, 5'd0, 64'h0);
        // Wrong-unit done is ignored
        mul_done = 1'b1; mul_res = 64'hDEAD;
        #1;
        chk("wrong_done_wb", XLEN'(wb_vld), 0);
        tick();
        mul_done = 1'b0;
        #1;
        chk("wrong_done_busy", XLEN'(busy_vld), 1);
        div_done = 1'b1; div_res = 64'hE0;
        #1;
        chk_wb("div14_wb", 5'd14, 64'hE0);
        tick();
        div_done = 1'b0;
        #1;
        chk("div14_busy", XLEN'(busy_vld), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
